reg_file_mp: RTL and testbench

// Parametrised multi-read-port register file; successor to the 8-bit 64-entry two-read regfile.
// - Configurable width, depth and read-port count; optional hardwired-zero register 0; optional write-to-read bypass.
// - Hardware clear sequencer zeroes every entry after reset, so no software init loop is needed.
// - Sits between decode (read addresses) and writeback (write port) in the core datapath.

---
 rtl/reg_file_mp_if.sv | 32 +++
 rtl/reg_file_mp.sv | 101 ++++++++++
 tb/tb_reg_file_mp.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/reg_file_mp_if.sv
//------------------------------------------------------------------------------
// Module   : reg_file_mp_if
// Brief    : Write port, packed read ports and status of the multi-port regfile.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface reg_file_mp_if #(
   parameter int DATA_WIDTH   = 8,
   parameter int ADDR_WIDTH   = 6,
   parameter int NUM_RD_PORTS = 2
);
   logic                               wr_en;
   logic [ADDR_WIDTH-1:0]              wr_addr;
   logic [DATA_WIDTH-1:0]              wr_data;
   logic                               wr_ready;
   logic [NUM_RD_PORTS*ADDR_WIDTH-1:0] rd_addr;
   logic [NUM_RD_PORTS*DATA_WIDTH-1:0] rd_data;
   logic                               busy;

   modport master (
      output wr_en, wr_addr, wr_data, rd_addr,
      input  wr_ready, rd_data, busy
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, rd_addr,
      output wr_ready, rd_data, busy
   );
endinterface

`default_nettype wire

// File: rtl/reg_file_mp.sv
//------------------------------------------------------------------------------
// Module   : reg_file_mp
// Brief    : Parametrised multi-read-port register file with hardware clear.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module reg_file_mp #(
   parameter int DATA_WIDTH   = 8,
   parameter int ADDR_WIDTH   = 6,
   parameter int NUM_RD_PORTS = 2,
   parameter int ZERO_REG     = 1,
   parameter int BYPASS       = 1
) (
   input  wire logic     clk,
   input  wire logic     rst,
   reg_file_mp_if.slave  bus
);
   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] c_last_idx = (ADDR_WIDTH + 1)'(DEPTH - 1);

   typedef enum logic [0:0] {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } state_t;

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH:0]     clr_cnt_q, clr_cnt_d;
   logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

   logic                    mem_we;
   logic [ADDR_WIDTH-1:0]   mem_waddr;
   logic [DATA_WIDTH-1:0]   mem_wdata;
   logic                    wr_to_zero;

   assign wr_to_zero = (ZERO_REG != 0) && (bus.wr_addr == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= CLEAR;
         clr_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
      end
   end

   // The clear sequencer and the external write share the single storage write port.
   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      mem_we    = 1'b0;
      mem_waddr = bus.wr_addr;
      mem_wdata = bus.wr_data;
      case (state_q)
         CLEAR: begin
            mem_we    = 1'b1;
            mem_waddr = clr_cnt_q[ADDR_WIDTH-1:0];
            mem_wdata = '0;
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (clr_cnt_q == c_last_idx) begin
               state_d = RUN;
            end
         end
         RUN: begin
            mem_we = bus.wr_en && !wr_to_zero;
         end
         default: begin
            state_d = CLEAR;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mem_q[0] <= '0;
      end else if (mem_we) begin
         mem_q[mem_waddr] <= mem_wdata;
      end
   end

   assign bus.busy     = (state_q != RUN);
   assign bus.wr_ready = (state_q == RUN);

   for (genvar i = 0; i < NUM_RD_PORTS; i++) begin : g_rd
      logic [ADDR_WIDTH-1:0] raddr;
      logic                  hit_zero;
      logic                  hit_byp;

      assign raddr    = bus.rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      assign hit_zero = (ZERO_REG != 0) && (raddr == '0);
      assign hit_byp  = (BYPASS != 0) && (state_q == RUN) && bus.wr_en
                        && (bus.wr_addr == raddr);
      assign bus.rd_data[i*DATA_WIDTH +: DATA_WIDTH] =
         ((state_q != RUN) || hit_zero) ? '0 :
         hit_byp                        ? bus.wr_data :
                                          mem_q[raddr];
   end
endmodule

`default_nettype wire

// File: tb/tb_reg_file_mp.sv
//------------------------------------------------------------------------------
// Module   : tb_reg_file_mp
// Brief    : Scoreboard bench for reg_file_mp in two configurations.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_reg_file_mp;
   logic        clk = 1'b0;
   logic        rst;
   logic        wr_en;
   logic [5:0]  wr_addr;
   logic [7:0]  wr_data;
   logic [23:0] rda;
   logic [11:0] rdb;

   int n_chk  = 0;
   int n_pass = 0;

   typedef struct {
      string      tag;
      int         dut;
      int         port;
      logic [7:0] exp;
   } exp_t;
   exp_t sb[$];

   always #5 clk = ~clk;

   // A: zero register + bypass, 4 read ports. B: plain storage, no bypass, 2 read ports.
   reg_file_mp_if #(.DATA_WIDTH(8), .ADDR_WIDTH(6), .NUM_RD_PORTS(4)) ifa ();
   reg_file_mp_if #(.DATA_WIDTH(8), .ADDR_WIDTH(6), .NUM_RD_PORTS(2)) ifb ();

   assign ifa.wr_en   = wr_en;
   assign ifa.wr_addr = wr_addr;
   assign ifa.wr_data = wr_data;
   assign ifa.rd_addr = rda;
   assign ifb.wr_en   = wr_en;
   assign ifb.wr_addr = wr_addr;
   assign ifb.wr_data = wr_data;
   assign ifb.rd_addr = rdb;

   reg_file_mp #(.DATA_WIDTH(8), .ADDR_WIDTH(6), .NUM_RD_PORTS(4), .ZERO_REG(1), .BYPASS(1))
      dut_a (.clk(clk), .rst(rst), .bus(ifa));
   reg_file_mp #(.DATA_WIDTH(8), .ADDR_WIDTH(6), .NUM_RD_PORTS(2), .ZERO_REG(0), .BYPASS(0))
      dut_b (.clk(clk), .rst(rst), .bus(ifb));

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      else n_pass++;
   endtask

   function automatic logic [7:0] rd_of(input int d, input int p);
      return (d == 0) ? ifa.rd_data[p*8 +: 8] : ifb.rd_data[p*8 +: 8];
   endfunction

   task automatic push(input string tag, input int d, input int p, input logic [7:0] e);
      exp_t x;
      x.tag = tag; x.dut = d; x.port = p; x.exp = e;
      sb.push_back(x);
   endtask

   task automatic drain();
      exp_t x;
      while (sb.size() > 0) begin
         x = sb.pop_front();
         check_val(x.tag, {24'd0, rd_of(x.dut, x.port)}, {24'd0, x.exp});
      end
   endtask

   task automatic set_all(input logic [5:0] a);
      rda = {4{a}};
      rdb = {2{a}};
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic count_busy(input string tag);
      int n = 0;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (!ifa.busy) break;
         n++;
      end
      check_val({tag, "_busy_cycles"}, n, 64);
      check_val({tag, "_b_busy"}, {31'd0, ifb.busy}, 0);
      check_val({tag, "_wr_ready"}, {30'd0, ifa.wr_ready, ifb.wr_ready}, 3);
   endtask

   initial begin
      rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      rda = '0; rdb = '0;

      // Reset state and full clear length
      step();
      @(negedge clk);
      check_val("rst_status", {28'd0, ifa.busy, ifa.wr_ready, ifb.busy, ifb.wr_ready}, 4'b1010);
      check_val("rst_rd", {8'd0, ifa.rd_data}, 0);
      step();
      rst = 1'b0;
      count_busy("init");
      step();

      for (int a = 0; a < 64; a++) begin
         set_all(6'(a));
         for (int p = 0; p < 4; p++) push("scan_a", 0, p, 8'h00);
         for (int p = 0; p < 2; p++) push("scan_b", 1, p, 8'h00);
         @(negedge clk); drain();
         step();
      end

      // Write 0xA5 to 5: B shows old value until next cycle, A forwards it
      wr_en = 1'b1; wr_addr = 6'd5; wr_data = 8'hA5; set_all(6'd5);
      push("wr5_b0_same", 1, 0, 8'h00); push("wr5_b1_same", 1, 1, 8'h00);
      push("wr5_a3_byp", 0, 3, 8'hA5);
      @(negedge clk); drain();
      step();
      wr_en = 1'b0;
      push("wr5_b0_next", 1, 0, 8'hA5); push("wr5_b1_next", 1, 1, 8'hA5);
      push("wr5_a0_next", 0, 0, 8'hA5);
      @(negedge clk); drain();
      step();

      // Bypass on port 1 only; other ports keep reading their own addresses
      wr_en = 1'b1; wr_addr = 6'd9; wr_data = 8'h3C;
      rda = {6'd0, 6'd0, 6'd9, 6'd5}; rdb = {6'd9, 6'd5};
      push("byp_a1", 0, 1, 8'h3C); push("byp_a0", 0, 0, 8'hA5);
      push("byp_b1_old", 1, 1, 8'h00); push("byp_b0", 1, 0, 8'hA5);
      @(negedge clk); drain();
      step();
      wr_addr = 6'd7; wr_data = 8'h42;
      step();
      wr_addr = 6'd50; wr_data = 8'h5A;
      step();

      // Write 0xFF to address 0
      wr_addr = 6'd0; wr_data = 8'hFF; set_all(6'd0);
      for (int p = 0; p < 4; p++) push("zero_a_same", 0, p, 8'h00);
      push("zero_b_same", 1, 0, 8'h00);
      @(negedge clk); drain();
      check_val("zero_wr_ready", {31'd0, ifa.wr_ready}, 1);
      step();
      wr_en = 1'b0;
      for (int p = 0; p < 4; p++) push("zero_a_next", 0, p, 8'h00);
      push("zero_b0_next", 1, 0, 8'hFF); push("zero_b1_next", 1, 1, 8'hFF);
      @(negedge clk); drain();
      step();

      // Four independent read ports
      rda = {6'd7, 6'd9, 6'd5, 6'd0}; rdb = {6'd7, 6'd50};
      push("mp_a0", 0, 0, 8'h00); push("mp_a1", 0, 1, 8'hA5);
      push("mp_a2", 0, 2, 8'h3C); push("mp_a3", 0, 3, 8'h42);
      push("mp_b0", 1, 0, 8'h5A); push("mp_b1", 1, 1, 8'h42);
      @(negedge clk); drain();
      step();

      // Write during clear is dropped; reset mid-clear restarts the sweep
      rst = 1'b1;
      step();
      rst = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      wr_en = 1'b1; wr_addr = 6'd63; wr_data = 8'h77; set_all(6'd50);
      push("clr_rd_a", 0, 0, 8'h00); push("clr_rd_b", 1, 1, 8'h00);
      @(negedge clk); drain();
      check_val("clr_wr_ready", {30'd0, ifa.wr_ready, ifb.wr_ready}, 0);
      check_val("clr_busy", {30'd0, ifa.busy, ifb.busy}, 3);
      step();
      wr_en = 1'b0;
      repeat (19) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      count_busy("restart");
      step();

      set_all(6'd63);
      push("drop63_a", 0, 2, 8'h00); push("drop63_b", 1, 0, 8'h00);
      @(negedge clk); drain();
      step();
      rda = {6'd50, 6'd7, 6'd9, 6'd5}; rdb = {6'd0, 6'd50};
      push("post_a0", 0, 0, 8'h00); push("post_a3", 0, 3, 8'h00);
      push("post_b0", 1, 0, 8'h00); push("post_b1", 1, 1, 8'h00);
      @(negedge clk); drain();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

`default_nettype wire
